// File: rtl/vga_fb_arbiter_if.sv
// Frame-buffer arbiter bus: the game-logic writer handshake plus the
// single-port RAM port, bundled so the arbiter and its neighbours share one
// connection.
//   wr_req/wr_addr/wr_data : writer request, held until wr_ack
//   wr_ack                 : one-cycle grant, write issued to RAM this cycle
//   ram_addr/ram_we/ram_wdata : registered RAM command from the arbiter
//   ram_rdata              : RAM read data, one cycle after ram_addr
// modport slave  : the arbiter
// modport master : the writer + RAM side
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  wr_req, wr_addr, wr_data, ram_rdata,
        output wr_ack, ram_addr, ram_we, ram_wdata
    );

    modport master (
        output wr_req, wr_addr, wr_data, ram_rdata,
        input  wr_ack, ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port frame-buffer RAM between the VGA display fetch, a
// pixel writer and a frame-clear engine. Display fetches own every visible
// cycle; clear writes, then writer writes, fill the blanking cycles.
// Ports:
//   clk25, reset           : pixel clock, async active-high reset
//   t_active/t_x/t_y       : timing generator visible flag and coordinates
//   t_hSync/t_vSync        : timing generator syncs
//   t_screenEnd            : one-cycle end-of-frame pulse
//   bus                    : writer handshake + RAM port (slave side)
//   clear_start            : pulse to request a full-buffer clear
//   clear_busy/clear_done  : clear pending/running, last-clear-write pulse
//   pix_data/pix_active    : pixel to the DAC and its visible flag
//   hSync/vSync            : syncs re-timed to match pix_data
module vga_fb_arbiter #(
    parameter int                WIDTH     = 640,
    parameter int                HEIGHT    = 480,
    parameter int                ADDR_W    = 19,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                    clk25,
    input  logic                    reset,
    input  logic                    t_active,
    input  logic [9:0]              t_x,
    input  logic [8:0]              t_y,
    input  logic                    t_hSync,
    input  logic                    t_vSync,
    input  logic                    t_screenEnd,
    vga_fb_arbiter_if.slave         bus,
    input  logic                    clear_start,
    output logic                    clear_busy,
    output logic                    clear_done,
    output logic [DATA_W-1:0]       pix_data,
    output logic                    pix_active,
    output logic                    hSync,
    output logic                    vSync
);
    localparam int                STAGES = 2;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_RUN} cstate_t;

    cstate_t           state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] x_ext, y_ext, disp_addr;
    logic              clr_slot, wr_slot;

    // display address = y*WIDTH + x
    assign x_ext = ADDR_W'(t_x);
    assign y_ext = ADDR_W'(t_y);
    generate
        if (WIDTH == 640) begin : g_shift_add
            assign disp_addr = (y_ext << 9) + (y_ext << 7) + x_ext;
        end else begin : g_mult
            assign disp_addr = y_ext * ADDR_W'(WIDTH) + x_ext;
        end
    endgenerate

    // display > clear > writer
    assign clr_slot   = !t_active && (state == C_RUN);
    assign wr_slot    = !t_active && (state != C_RUN) && bus.wr_req;
    // the ack is the grant itself; masked so reset never acknowledges
    assign bus.wr_ack = wr_slot && !reset;

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            bus.ram_addr  <= '0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= '0;
        end else if (t_active) begin
            bus.ram_addr  <= disp_addr;
            bus.ram_we    <= 1'b0;
        end else if (clr_slot) begin
            bus.ram_addr  <= clr_cnt;
            bus.ram_we    <= 1'b1;
            bus.ram_wdata <= CLEAR_VAL;
        end else if (wr_slot) begin
            bus.ram_addr  <= bus.wr_addr;
            bus.ram_we    <= 1'b1;
            bus.ram_wdata <= bus.wr_data;
        end else begin
            bus.ram_we    <= 1'b0;
        end
    end

    // Clear engine: armed by clear_start, begins at the next frame end and
    // then steals blanking cycles until every pixel has been written.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            state      <= C_IDLE;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                C_IDLE: begin
                    // a screenEnd in this same cycle is not used; the
                    // clear waits for the following frame end
                    if (clear_start) begin
                        state      <= C_WAIT;
                        clear_busy <= 1'b1;
                    end
                end
                C_WAIT: begin
                    if (t_screenEnd) begin
                        state   <= C_RUN;
                        clr_cnt <= '0;
                    end
                end
                C_RUN: begin
                    if (clr_slot) begin
                        if (clr_cnt == LAST) begin
                            state      <= C_IDLE;
                            clear_busy <= 1'b0;
                            clear_done <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
                default: state <= C_IDLE;
            endcase
        end
    end

    // Two-stage delay matching address register + RAM read latency.
    // Syncs idle high, so their stages reset to 1.
    logic [STAGES:1] vld_pipe, hs_pipe, vs_pipe;

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], t_active};
            hs_pipe  <= {hs_pipe[STAGES-1:1], t_hSync};
            vs_pipe  <= {vs_pipe[STAGES-1:1], t_vSync};
        end
    end

    assign pix_active = vld_pipe[STAGES];
    assign hSync      = hs_pipe[STAGES];
    assign vSync      = vs_pipe[STAGES];
    assign pix_data   = pix_active ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: a full-size instance for addressing, grant and
// pipeline vectors, and a 16x8 instance driven by a small timing generator
// for clear-engine and whole-frame behaviour.
module tb_vga_fb_arbiter;
    logic clk25 = 1'b0;
    logic reset = 1'b1;
    always #20 clk25 = ~clk25;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- full-size instance ----------------
    logic       b_act = 1'b0, b_hs = 1'b1, b_vs = 1'b1, b_se = 1'b0, b_cs = 1'b0;
    logic [9:0] b_x = '0;
    logic [8:0] b_y = '0;
    logic       b_busy, b_done, b_pa, b_hso, b_vso;
    logic [7:0] b_pix;

    vga_fb_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bif ();

    vga_fb_arbiter #(.WIDTH(640), .HEIGHT(480), .ADDR_W(19), .DATA_W(8), .CLEAR_VAL(8'h00)) u_big (
        .clk25(clk25), .reset(reset),
        .t_active(b_act), .t_x(b_x), .t_y(b_y),
        .t_hSync(b_hs), .t_vSync(b_vs), .t_screenEnd(b_se),
        .bus(bif.slave),
        .clear_start(b_cs), .clear_busy(b_busy), .clear_done(b_done),
        .pix_data(b_pix), .pix_active(b_pa), .hSync(b_hso), .vSync(b_vso)
    );

    logic [7:0] mem_b [0:524287];
    always @(posedge clk25) begin
        if (reset) mem_b[1925] <= 8'hA5;
        else if (bif.ram_we) mem_b[bif.ram_addr] <= bif.ram_wdata;
        bif.ram_rdata <= mem_b[bif.ram_addr];
    end

    // ---------------- small instance + timing generator ----------------
    logic [4:0] hc;
    logic [3:0] vc;
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == 5'd23) begin
            hc <= '0;
            vc <= (vc == 4'd11) ? 4'd0 : vc + 4'd1;
        end else begin
            hc <= hc + 5'd1;
        end
    end

    logic       s_act, s_hs, s_vs, s_se;
    logic [9:0] s_x;
    logic [8:0] s_y;
    assign s_act = (hc < 5'd16) && (vc < 4'd8);
    assign s_x   = 10'(hc);
    assign s_y   = 9'(vc);
    assign s_hs  = !((hc >= 5'd18) && (hc < 5'd21));
    assign s_vs  = !(vc == 4'd9);
    assign s_se  = (hc == 5'd23) && (vc == 4'd11);

    logic       s_cs = 1'b0;
    logic       s_busy, s_done, s_pa, s_hso, s_vso;
    logic [7:0] s_pix;

    vga_fb_arbiter_if #(.ADDR_W(7), .DATA_W(8)) sif ();

    vga_fb_arbiter #(.WIDTH(16), .HEIGHT(8), .ADDR_W(7), .DATA_W(8), .CLEAR_VAL(8'h00)) u_small (
        .clk25(clk25), .reset(reset),
        .t_active(s_act), .t_x(s_x), .t_y(s_y),
        .t_hSync(s_hs), .t_vSync(s_vs), .t_screenEnd(s_se),
        .bus(sif.slave),
        .clear_start(s_cs), .clear_busy(s_busy), .clear_done(s_done),
        .pix_data(s_pix), .pix_active(s_pa), .hSync(s_hso), .vSync(s_vso)
    );

    logic [7:0] mem_s [0:127];
    always @(posedge clk25) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) mem_s[i] <= 8'hFF;
        end else if (sif.ram_we) begin
            mem_s[sif.ram_addr] <= sif.ram_wdata;
        end
        sif.ram_rdata <= mem_s[sif.ram_addr];
    end

    // ---------------- monitors ----------------
    int cyc = 0;
    always @(posedge clk25) cyc <= cyc + 1;

    logic mon_en = 1'b0;
    int clr_wr = 0, done_cnt = 0, first_addr = -1, first_wd = -1, ack_busy = 0;
    always @(negedge clk25) begin
        if (!mon_en) begin
            clr_wr <= 0; done_cnt <= 0; first_addr <= -1; first_wd <= -1; ack_busy <= 0;
        end else begin
            if (sif.ram_we && (s_busy || s_done)) begin
                clr_wr <= clr_wr + 1;
                if (first_addr < 0) begin
                    first_addr <= int'(sif.ram_addr);
                    first_wd   <= int'(sif.ram_wdata);
                end
            end
            if (s_done) done_cnt <= done_cnt + 1;
            if (sif.wr_ack && s_busy) ack_busy <= ack_busy + 1;
        end
    end

    logic prev_th = 1'b1, prev_tv = 1'b1, prev_ho = 1'b1, prev_vo = 1'b1;
    int th_fall = 0, tv_fall = 0, h_diff = -1, v_diff = -1, pa_cnt = 0, pa_frame = -1;
    always @(negedge clk25) begin
        prev_th <= s_hs; prev_tv <= s_vs; prev_ho <= s_hso; prev_vo <= s_vso;
        if (prev_th && !s_hs)  th_fall <= cyc;
        if (prev_tv && !s_vs)  tv_fall <= cyc;
        if (prev_ho && !s_hso) h_diff  <= cyc - th_fall;
        if (prev_vo && !s_vso) v_diff  <= cyc - tv_fall;
        if (s_se) begin
            pa_frame <= pa_cnt + int'(s_pa);
            pa_cnt   <= 0;
        end else begin
            pa_cnt <= pa_cnt + int'(s_pa);
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic act; int x; int y; logic req; int wa; int wd;
        logic e_ack; int e_addr; logic e_we; int e_wd;
    } vec_t;
    vec_t vt [9];

    initial begin
        // act x    y    req wa      wd     ack addr    we  wd
        vt[0] = '{1'b1, 5,   3,   1'b1, 100,    8'h3C, 1'b0, 1925,   1'b0, 0};
        vt[1] = '{1'b0, 0,   0,   1'b1, 100,    8'h3C, 1'b1, 100,    1'b1, 8'h3C};
        vt[2] = '{1'b1, 639, 479, 1'b1, 100,    8'h3C, 1'b0, 307199, 1'b0, 0};
        vt[3] = '{1'b0, 0,   0,   1'b0, 0,      0,     1'b0, 307199, 1'b0, 0};
        vt[4] = '{1'b0, 0,   0,   1'b1, 524287, 8'h81, 1'b1, 524287, 1'b1, 8'h81};
        vt[5] = '{1'b1, 0,   0,   1'b0, 0,      0,     1'b0, 0,      1'b0, 0};
        vt[6] = '{1'b0, 0,   0,   1'b0, 0,      0,     1'b0, 0,      1'b0, 0};
        vt[7] = '{1'b1, 0,   1,   1'b0, 0,      0,     1'b0, 640,    1'b0, 0};
        vt[8] = '{1'b1, 100, 200, 1'b0, 0,      0,     1'b0, 128100, 1'b0, 0};

        bif.wr_req = 1'b1; bif.wr_addr = 19'd200; bif.wr_data = 8'h55;
        sif.wr_req = 1'b0; sif.wr_addr = '0; sif.wr_data = '0;

        // reset state, with a pending writer request
        repeat (2) @(negedge clk25);
        chk("rst_ack",   int'(bif.wr_ack), 0);
        chk("rst_addr",  int'(bif.ram_addr), 0);
        chk("rst_we",    int'(bif.ram_we), 0);
        chk("rst_wdata", int'(bif.ram_wdata), 0);
        chk("rst_busy",  int'(b_busy), 0);
        chk("rst_done",  int'(b_done), 0);
        chk("rst_pa",    int'(b_pa), 0);
        chk("rst_pix",   int'(b_pix), 0);
        chk("rst_hs",    int'(b_hso), 1);
        chk("rst_vs",    int'(b_vso), 1);
        bif.wr_req = 1'b0;
        reset = 1'b0;

        // table-driven grant/address vectors
        @(negedge clk25);
        for (int i = 0; i < 9; i++) begin
            b_act = vt[i].act; b_x = 10'(vt[i].x); b_y = 9'(vt[i].y);
            bif.wr_req = vt[i].req; bif.wr_addr = 19'(vt[i].wa); bif.wr_data = 8'(vt[i].wd);
            #1;
            chk($sformatf("v%0d_ack", i), int'(bif.wr_ack), int'(vt[i].e_ack));
            @(negedge clk25);
            chk($sformatf("v%0d_addr", i), int'(bif.ram_addr), vt[i].e_addr);
            chk($sformatf("v%0d_we", i), int'(bif.ram_we), int'(vt[i].e_we));
            if (vt[i].e_we)
                chk($sformatf("v%0d_wd", i), int'(bif.ram_wdata), vt[i].e_wd);
        end

        // display pipeline: 2-cycle latency from coordinates to pixel
        b_act = 1'b0; bif.wr_req = 1'b0;
        repeat (2) @(negedge clk25);
        chk("pipe_idle_pa", int'(b_pa), 0);
        b_act = 1'b1; b_x = 10'd5; b_y = 9'd3;
        @(negedge clk25);
        b_act = 1'b0;
        chk("pipe_c1_pa", int'(b_pa), 0);
        @(negedge clk25);
        chk("pipe_c2_pa",  int'(b_pa), 1);
        chk("pipe_c2_pix", int'(b_pix), 8'hA5);
        @(negedge clk25);
        chk("pipe_c3_pa",  int'(b_pa), 0);
        chk("pipe_c3_pix", int'(b_pix), 0);

        // reset mid-frame with a pending request and syncs low
        b_act = 1'b0; bif.wr_req = 1'b1; bif.wr_addr = 19'd300; bif.wr_data = 8'h66;
        b_hs = 1'b0; b_vs = 1'b0;
        #5 reset = 1'b1;
        #1;
        chk("mrst_ack",  int'(bif.wr_ack), 0);
        chk("mrst_we",   int'(bif.ram_we), 0);
        chk("mrst_addr", int'(bif.ram_addr), 0);
        chk("mrst_hs",   int'(b_hso), 1);
        @(negedge clk25);
        chk("mrst_ack2", int'(bif.wr_ack), 0);
        chk("mrst_vs",   int'(b_vso), 1);
        bif.wr_req = 1'b0;
        reset = 1'b0;
        @(negedge clk25);
        chk("rel_c1_hs", int'(b_hso), 1);
        chk("rel_c1_vs", int'(b_vso), 1);
        @(negedge clk25);
        chk("rel_c2_hs", int'(b_hso), 0);
        chk("rel_c2_vs", int'(b_vso), 0);
        b_hs = 1'b1; b_vs = 1'b1;

        // clear engine on the small instance
        repeat (5) @(negedge clk25);
        mon_en = 1'b1;
        @(negedge clk25);
        s_cs = 1'b1;
        @(negedge clk25);
        s_cs = 1'b0;
        chk("clr_busy", int'(s_busy), 1);
        for (int k = 0; k < 3000 && first_addr < 0; k++) @(negedge clk25);
        chk("clr_started", int'(first_addr >= 0), 1);
        chk("clr_first_addr", first_addr, 0);
        chk("clr_first_wd", first_wd, 0);
        // extra clear_start pulses while running must be ignored
        s_cs = 1'b1;
        repeat (2) @(negedge clk25);
        s_cs = 1'b0;
        sif.wr_req = 1'b1; sif.wr_addr = 7'd50; sif.wr_data = 8'h77;
        for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk25);
        chk("clr_done_seen", int'(done_cnt > 0), 1);
        begin
            logic got;
            got = 1'b0;
            for (int k = 0; k < 1000 && !got; k++) begin
                @(negedge clk25);
                got = sif.wr_ack;
            end
            chk("wr_after_clear_ack", int'(got), 1);
        end
        @(negedge clk25);
        sif.wr_req = 1'b0;
        repeat (4) @(negedge clk25);
        chk("clr_writes", clr_wr, 128);
        chk("clr_done_once", done_cnt, 1);
        chk("clr_ack_while_busy", ack_busy, 0);
        chk("clr_busy_end", int'(s_busy), 0);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 128; i++)
                if (mem_s[i] !== ((i == 50) ? 8'h77 : 8'h00)) bad++;
            chk("clr_mem_bad", bad, 0);
        end

        // whole frames: visible count and sync alignment
        repeat (700) @(negedge clk25);
        chk("frame_pa_count", pa_frame, 128);
        chk("hsync_delay", h_diff, 2);
        chk("vsync_delay", v_diff, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM between three users: the VGA display fetch, a game-logic pixel writer, and a built-in frame-clear engine.
- Sits between the VGA timing generator (active, x, y, hSync, vSync, screenEnd) and the pixel DAC / RAM.
- Display reads always win during the visible area. Clear and writer accesses are scheduled into blanking cycles.
- Sync and active signals are re-timed so they stay aligned with the returned pixel data.

Parameters:
- WIDTH, 640, visible pixels per line.
- HEIGHT, 480, visible lines per frame.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- DATA_W, 8, pixel word width.
- CLEAR_VAL, 0, value written by the clear engine.

Ports:
- clk25  in  1  25 MHz pixel clock
- reset  in  1  asynchronous, active-high
- t_active  in  1  timing-generator visible-area flag
- t_x  in  10  timing-generator x coordinate
- t_y  in  9  timing-generator y coordinate
- t_hSync  in  1  timing-generator hSync
- t_vSync  in  1  timing-generator vSync
- t_screenEnd  in  1  one-cycle end-of-frame pulse
- wr_req  in  1  writer request; held until wr_ack
- wr_addr  in  ADDR_W  writer pixel address
- wr_data  in  DATA_W  writer pixel data
- wr_ack  out  1  one-cycle pulse; write issued to RAM this cycle
- clear_start  in  1  pulse; request a full-buffer clear
- clear_busy  out  1  clear pending or in progress
- clear_done  out  1  one-cycle pulse when the last clear write is issued
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_rdata  in  DATA_W  RAM read data; valid 1 cycle after ram_addr
- pix_data  out  DATA_W  pixel to DAC; forced to 0 when pix_active = 0
- pix_active  out  1  t_active delayed 2 cycles
- hSync  out  1  t_hSync delayed 2 cycles
- vSync  out  1  t_vSync delayed 2 cycles

Behaviour:
- **Reset values:**
  - ram_addr = 0, ram_we = 0, ram_wdata = 0, wr_ack = 0.
  - clear_busy = 0, clear_done = 0, pix_data = 0, pix_active = 0.
  - hSync = 1 and vSync = 1 (idle level); sync delay stages reset to 1.
  - Clear FSM returns to C_IDLE. Reset mid-clear abandons the clear with no done pulse.
- **Per-cycle grant:** priority is display > clear > writer.
  - Display slot (t_active = 1): ram_addr <= t_y*WIDTH + t_x, ram_we <= 0.
    - Multiply implemented as shift-add when WIDTH = 640: (y<<9)+(y<<7)+x.
  - Clear slot (t_active = 0 and FSM in C_RUN): ram_addr <= clr_cnt, ram_we <= 1, ram_wdata <= CLEAR_VAL.
  - Writer slot (t_active = 0, FSM not in C_RUN, wr_req = 1): ram_addr <= wr_addr, ram_we <= 1, ram_wdata <= wr_data, wr_ack = 1 in the same cycle (combinational from grant).
  - Otherwise: ram_we <= 0, ram_addr holds its previous value.
- **Writer request rule:** wr_addr and wr_data must stay stable while wr_req is high and unacked. A back-to-back request is served at most one write per cycle.
- **Clear FSM:**
  - C_IDLE: on clear_start go to C_WAIT, clear_busy = 1.
  - C_WAIT: on t_screenEnd go to C_RUN with clr_cnt = 0.
  - C_RUN: clr_cnt increments only on cycles it owns the RAM.
    - When clr_cnt = WIDTH*HEIGHT-1 is issued, pulse clear_done and go to C_IDLE.
    - A clear spans several frames; it uses blanking cycles only.
  - clear_start while clear_busy = 1 is ignored.
  - clear_start in the same cycle as t_screenEnd in C_IDLE goes to C_WAIT; C_RUN starts at the next screenEnd.
- **Display pipeline:** 2-cycle latency (address register, then RAM read).
  - t_active, t_hSync and t_vSync pass through a 2-stage delay.
  - pix_data = pix_active ? ram_rdata : 0.
- **Address wrap:** writer addresses >= WIDTH*HEIGHT are still forwarded unchanged. Range checking is the writer's responsibility.

Test Plan:
- Reset asserted mid-frame with wr_req = 1 → all outputs at reset values, no wr_ack, and hSync = vSync = 1 until 2 cycles after release.
- t_active = 1, t_x = 5, t_y = 3, wr_req = 1 → ram_addr = 1925 next cycle, ram_we = 0, wr_ack = 0.
  - Preload RAM[1925] = 0xA5 → pix_data = 0xA5 with pix_active = 1 exactly 2 cycles after the input.
- t_active = 0, wr_req = 1, wr_addr = 100, wr_data = 0x3C → wr_ack pulses 1 cycle, then ram_we = 1, ram_addr = 100, ram_wdata = 0x3C.
  - Keep wr_req high into a t_active = 1 region → no further ack until blanking.
- clear_start, then t_screenEnd → clear_busy high, and the first blanking cycle writes addr 0 with CLEAR_VAL.
  - A wr_req raised during C_RUN is held off (no wr_ack) until clear_done.
  - clear_done pulses once, after exactly 307200 clear writes (count ram_we cycles).
- clear_start pulses while in C_RUN → ignored; total clear writes = 307200.
- Full-frame run with the real timing generator → pix_active high for exactly 640×480 cycles per frame.
  - Falling edges of hSync/vSync occur exactly 2 cycles after the corresponding t_hSync/t_vSync edges.
